filter_select_sequencer: RTL

//  Sits between the front-panel filter selector and the lowpass block, all in the clk_48 (48 kHz,
//  one clock per sample) domain. Debounces the requested filter setting and sequences each change

---
 rtl/filter_select_sequencer.sv | 103 ++++++++++
 1 files changed

// File: rtl/filter_select_sequencer.sv
// filter_select_sequencer: debounces the filter request and sequences each select change
// as fade-out, switch, settle and fade-in so the lowpass switchover never clicks.
module filter_select_sequencer #(
  parameter int DATA_W        = 16,
  parameter int FILT_W        = 3,
  parameter int RESET_FILTER  = 1,
  parameter int DEBOUNCE_SAMP = 480,
  parameter int RAMP_LOG2     = 8,
  parameter int SETTLE_SAMP   = 64
) (
  input  logic                     clk_48,
  input  logic                     reset_n,
  input  logic [FILT_W-1:0]        filter_req,
  output logic [FILT_W-1:0]        filter,
  input  logic signed [DATA_W-1:0] lp_in,
  output logic signed [DATA_W-1:0] audio_out,
  output logic                     busy
);
  localparam int DW = $clog2(DEBOUNCE_SAMP + 1);
  localparam int SW = $clog2(SETTLE_SAMP + 1);
  localparam int GW = RAMP_LOG2 + 1;
  localparam int PW = DATA_W + GW + 1;
  localparam logic [GW-1:0]     UNITY    = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [DW-1:0]     DEB_LAST = DW'(DEBOUNCE_SAMP - 1);
  localparam logic [SW-1:0]     SET_LAST = SW'(SETTLE_SAMP - 1);
  localparam logic [FILT_W-1:0] RST_F    = FILT_W'(RESET_FILTER);
  typedef enum logic [2:0] {IDLE, FADE_OUT, SWITCH, SETTLE, FADE_IN} state_t;
  state_t                   state_q, state_d;
  logic [FILT_W-1:0]        cand_q, cand_d, stable_q, stable_d, filter_q, filter_d;
  logic [DW-1:0]            deb_q, deb_d;
  logic [SW-1:0]            settle_q, settle_d;
  logic [GW-1:0]            gain_q, gain_d, gain_dn, gain_up;
  logic signed [DATA_W-1:0] audio_q, audio_d;
  logic                     busy_q, chg;
  logic signed [PW-1:0]     prod, scaled;
  always_comb begin
    cand_d   = filter_req != cand_q ? filter_req : cand_q;
    deb_d    = filter_req != cand_q ? '0 : deb_q == DEB_LAST ? deb_q : deb_q + 1'b1;
    stable_d = (filter_req == cand_q && deb_q == DEB_LAST) ? cand_q : stable_q;
  end
  assign chg     = stable_q != filter_q;
  assign gain_dn = gain_q == '0 ? gain_q : gain_q - 1'b1;
  assign gain_up = gain_q == UNITY ? gain_q : gain_q + 1'b1;
  // Fade exits look at the next gain so the switch/idle follows the last ramp step directly.
  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    filter_d = filter_q;
    settle_d = settle_q;
    unique case (state_q)
      IDLE:     state_d = chg ? FADE_OUT : IDLE;
      FADE_OUT: begin
        state_d = !chg ? FADE_IN : gain_dn == '0 ? SWITCH : FADE_OUT;
        gain_d  = chg ? gain_dn : gain_q;
      end
      SWITCH: begin
        filter_d = stable_q;
        settle_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        settle_d = settle_q + 1'b1;
        state_d  = chg ? SWITCH : settle_q == SET_LAST ? FADE_IN : SETTLE;
      end
      FADE_IN: begin
        state_d = chg ? FADE_OUT : gain_up == UNITY ? IDLE : FADE_IN;
        gain_d  = chg ? gain_q : gain_up;
      end
      default:  state_d = IDLE;
    endcase
  end
  always_comb begin
    prod    = $signed({{(GW + 1){lp_in[DATA_W-1]}}, lp_in}) * $signed({{DATA_W{1'b0}}, 1'b0, gain_q});
    scaled  = prod >>> RAMP_LOG2;
    audio_d = scaled[DATA_W-1:0];
  end
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cand_q   <= RST_F;
      stable_q <= RST_F;
      filter_q <= RST_F;
      deb_q    <= '0;
      settle_q <= '0;
      gain_q   <= UNITY;
      audio_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      filter_q <= filter_d;
      deb_q    <= deb_d;
      settle_q <= settle_d;
      gain_q   <= gain_d;
      audio_q  <= audio_d;
      busy_q   <= state_d != IDLE;
    end
  end
  assign filter    = filter_q;
  assign audio_out = audio_q;
  assign busy      = busy_q;
endmodule
